// File: rtl/p405s_icu_pkg.sv
// Shared definitions for the ICU valid-bit array: default geometry,
// flash-sweep controller state encoding and a small width helper.
package p405s_icu_pkg;

  localparam int DEF_NUM_SETS    = 32;
  localparam int DEF_NUM_WAYS    = 2;
  localparam int DEF_CLR_PER_CYC = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SWEEP = 2'b01,
    ST_DONE  = 2'b10
  } sweep_state_e;

  // Width of a way-select field; a single-way array still gets one bit.
  function automatic int way_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/p405s_icu_vb_sweep_ctl.sv
// Flash-invalidate controller: walks the set space CLR_PER_CYC sets per
// cycle and raises one clear enable per set in the group being swept.
module p405s_icu_vb_sweep_ctl
  import p405s_icu_pkg::*;
#(
  parameter int NUM_SETS    = DEF_NUM_SETS,
  parameter int CLR_PER_CYC = DEF_CLR_PER_CYC,
  parameter int IDX_W       = $clog2(NUM_SETS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flash_req,
  output logic [NUM_SETS-1:0] clr_en,
  output logic                flash_busy,
  output logic                flash_ack,
  output sweep_state_e        state
);

  // Base of the final group; when one group covers the whole array this is
  // zero and the step wraps to zero, so the sweep lasts a single cycle.
  localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(NUM_SETS - CLR_PER_CYC);
  localparam logic [IDX_W-1:0] STEP     = IDX_W'(CLR_PER_CYC);

  logic [IDX_W-1:0] ptr;

  // Sweep FSM with registered busy/ack; flashReq outside IDLE is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      flash_busy <= 1'b0;
      flash_ack  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (flash_req) begin
            state      <= ST_SWEEP;
            ptr        <= '0;
            flash_busy <= 1'b1;
          end
        end
        ST_SWEEP: begin
          ptr <= ptr + STEP;
          if (ptr == LAST_PTR) begin
            state      <= ST_DONE;
            flash_busy <= 1'b0;
            flash_ack  <= 1'b1;
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          flash_ack <= 1'b0;
        end
        default: begin
          state      <= ST_IDLE;
          flash_busy <= 1'b0;
          flash_ack  <= 1'b0;
        end
      endcase
    end
  end

  // Clear every set whose group base matches the sweep pointer.
  always_comb begin
    clr_en = '0;
    for (int s = 0; s < NUM_SETS; s++) begin
      clr_en[s] = (state == ST_SWEEP) &&
                  (ptr == IDX_W'((s / CLR_PER_CYC) * CLR_PER_CYC));
    end
  end

endmodule

// File: rtl/p405s_icu_vb_array.sv
// Instruction-cache valid-bit array: NUM_WAYS x NUM_SETS flops with a
// single write port, a registered read port with write/clear bypass, and
// a multi-cycle flash invalidate driven by the sweep controller.
module p405s_icu_vb_array
  import p405s_icu_pkg::*;
#(
  parameter int  NUM_SETS    = DEF_NUM_SETS,
  parameter int  NUM_WAYS    = DEF_NUM_WAYS,
  parameter int  CLR_PER_CYC = DEF_CLR_PER_CYC,
  parameter int  IDX_W       = $clog2(NUM_SETS),
  localparam int WAY_W       = way_width(NUM_WAYS)
) (
  input  logic                CB,
  input  logic                reset,
  input  logic                wrEn,
  input  logic [WAY_W-1:0]    wrWay,
  input  logic [IDX_W-1:0]    wrIndex,
  input  logic                wrBit,
  output logic                wrRdy,
  input  logic [IDX_W-1:0]    rdIndex,
  output logic [NUM_WAYS-1:0] rdVb,
  input  logic                flashReq,
  output logic                flashBusy,
  output logic                flashAck
);

  logic [NUM_SETS-1:0] vb     [NUM_WAYS];
  logic [NUM_SETS-1:0] vb_nxt [NUM_WAYS];
  logic [NUM_SETS-1:0] clr_en;
  logic [NUM_WAYS-1:0] rd_nxt;
  sweep_state_e        ctl_state;
  logic                wr_ok;

  p405s_icu_vb_sweep_ctl #(
    .NUM_SETS   (NUM_SETS),
    .CLR_PER_CYC(CLR_PER_CYC),
    .IDX_W      (IDX_W)
  ) u_sweep_ctl (
    .clk       (CB),
    .reset     (reset),
    .flash_req (flashReq),
    .clr_en    (clr_en),
    .flash_busy(flashBusy),
    .flash_ack (flashAck),
    .state     (ctl_state)
  );

  // Write handshake: a write transfers on a cycle where wrEn && wrRdy;
  // wrRdy is only high in IDLE and is withdrawn whenever flashReq is
  // present, so a flash request always wins over a same-cycle write.
  assign wrRdy = (ctl_state == ST_IDLE) & ~flashReq;
  assign wr_ok = wrEn & wrRdy;

  // Next array contents: sweep clears, then the accepted write; an
  // out-of-range way matches no row and is dropped.
  always_comb begin
    for (int w = 0; w < NUM_WAYS; w++) begin
      vb_nxt[w] = vb[w] & ~clr_en;
      if (wr_ok && (wrWay == WAY_W'(w))) begin
        vb_nxt[w][wrIndex] = wrBit;
      end
    end
  end

  // Read data comes from the next-state view so same-edge updates bypass.
  always_comb begin
    rd_nxt = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      rd_nxt[w] = vb_nxt[w][rdIndex];
    end
  end

  // Storage and registered read port.
  always_ff @(posedge CB) begin
    if (reset) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        vb[w] <= '0;
      end
      rdVb <= '0;
    end else begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        vb[w] <= vb_nxt[w];
      end
      rdVb <= rd_nxt;
    end
  end

endmodule

// File: tb/tb_p405s_icu_vb_array.sv
// Bench for the ICU valid-bit array: a default-geometry instance and a
// 64-set / 4-way / single-cycle-sweep instance, checked every cycle
// against a behavioural model of the array plus directed scenarios.
module tb_p405s_icu_vb_array;

  // ---------------- clock / reset ----------------
  logic CB = 1'b0;
  always #5 CB = ~CB;

  logic       rst       [2];
  logic       wr_en     [2];
  logic [1:0] wr_way    [2];
  logic [5:0] wr_index  [2];
  logic       wr_bit    [2];
  logic [5:0] rd_index  [2];
  logic       flash_req [2];
  logic       wr_rdy    [2];
  logic       busy      [2];
  logic       ack       [2];
  logic [1:0] rd_vb0;
  logic [3:0] rd_vb1;

  int tests = 0;
  int fails = 0;
  bit primed = 1'b0;

  // Geometry of the two instances.
  int nsets [2] = '{32, 64};
  int nways [2] = '{2, 4};
  int clrn  [2] = '{8, 64};

  // Reference model: valid bits per instance/way, sweep phase
  // (0 idle, 1 sweeping, 2 done) and number of groups already cleared.
  logic [63:0] mvb   [2][4];
  int          mphase[2];
  int          mgrp  [2];
  logic [3:0]  mrd   [2];

  p405s_icu_vb_array dut0 (
    .CB       (CB),
    .reset    (rst[0]),
    .wrEn     (wr_en[0]),
    .wrWay    (wr_way[0][0:0]),
    .wrIndex  (wr_index[0][4:0]),
    .wrBit    (wr_bit[0]),
    .wrRdy    (wr_rdy[0]),
    .rdIndex  (rd_index[0][4:0]),
    .rdVb     (rd_vb0),
    .flashReq (flash_req[0]),
    .flashBusy(busy[0]),
    .flashAck (ack[0])
  );

  p405s_icu_vb_array #(
    .NUM_SETS   (64),
    .NUM_WAYS   (4),
    .CLR_PER_CYC(64)
  ) dut1 (
    .CB       (CB),
    .reset    (rst[1]),
    .wrEn     (wr_en[1]),
    .wrWay    (wr_way[1]),
    .wrIndex  (wr_index[1]),
    .wrBit    (wr_bit[1]),
    .wrRdy    (wr_rdy[1]),
    .rdIndex  (rd_index[1]),
    .rdVb     (rd_vb1),
    .flashReq (flash_req[1]),
    .flashBusy(busy[1]),
    .flashAck (ack[1])
  );

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [3:0] rd_obs(input int d);
    return (d == 0) ? {2'b00, rd_vb0} : rd_vb1;
  endfunction

  // Apply one clock edge of the specified behaviour to the model.
  task automatic model_edge(input int d);
    logic rdy;
    int   base;
    if (rst[d]) begin
      for (int w = 0; w < 4; w++) mvb[d][w] = '0;
      mphase[d] = 0;
      mgrp[d]   = 0;
      mrd[d]    = '0;
    end else begin
      rdy = (mphase[d] == 0) && !flash_req[d];
      if (mphase[d] == 0) begin
        if (flash_req[d]) begin
          mphase[d] = 1;
          mgrp[d]   = 0;
        end
      end else if (mphase[d] == 1) begin
        base = mgrp[d] * clrn[d];
        for (int s = base; s < base + clrn[d]; s++)
          for (int w = 0; w < 4; w++) mvb[d][w][s] = 1'b0;
        mgrp[d]++;
        if (mgrp[d] == nsets[d] / clrn[d]) mphase[d] = 2;
      end else begin
        mphase[d] = 0;
      end
      if (rdy && wr_en[d] && (int'(wr_way[d]) < nways[d]))
        mvb[d][wr_way[d]][int'(wr_index[d]) % nsets[d]] = wr_bit[d];
      mrd[d] = '0;
      for (int w = 0; w < nways[d]; w++)
        mrd[d][w] = mvb[d][w][int'(rd_index[d]) % nsets[d]];
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    #1;
    if (primed) begin
      for (int d = 0; d < 2; d++)
        chk($sformatf("wrRdy%0d", d), {31'd0, wr_rdy[d]},
            {31'd0, (mphase[d] == 0) && !flash_req[d]});
    end
    @(posedge CB);
    for (int d = 0; d < 2; d++) model_edge(d);
    primed = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rdVb%0d", d), {28'd0, rd_obs(d)}, {28'd0, mrd[d]});
      chk($sformatf("busy%0d", d), {31'd0, busy[d]}, {31'd0, mphase[d] == 1});
      chk($sformatf("ack%0d", d),  {31'd0, ack[d]},  {31'd0, mphase[d] == 2});
    end
  endtask

  task automatic clear_inputs();
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b0; wr_en[d] = 1'b0; wr_way[d] = '0; wr_index[d] = '0;
      wr_bit[d] = 1'b0; rd_index[d] = '0; flash_req[d] = 1'b0;
    end
  endtask

  task automatic write(input int d, input int w, input int s, input logic b);
    wr_en[d] = 1'b1; wr_way[d] = 2'(w); wr_index[d] = 6'(s); wr_bit[d] = b;
    tick();
    wr_en[d] = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n_busy;
    int n_ack;
    int last_busy;
    int first_ack;

    clear_inputs();
    rst[0] = 1'b1; rst[1] = 1'b1;
    tick(); tick();
    rst[0] = 1'b0; rst[1] = 1'b0;
    chk("reset_rdvb",  {30'd0, rd_vb0}, 32'd0);
    chk("reset_busy",  {31'd0, busy[0]}, 32'd0);
    chk("reset_ack",   {31'd0, ack[0]}, 32'd0);
    chk("reset_wrrdy", {31'd0, wr_rdy[0]}, 32'd1);

    // Write way1 idx5, then read idx5.
    write(0, 1, 5, 1'b1);
    rd_index[0] = 6'd5;
    tick();
    chk("wr_then_rd", {30'd0, rd_vb0}, 32'b10);

    // Same-cycle write and read of idx7: bypass.
    rd_index[0] = 6'd7;
    write(0, 0, 7, 1'b1);
    chk("bypass", {31'd0, rd_vb0[0]}, 32'd1);

    // Populate everything, then flash.
    for (int s = 0; s < 32; s++)
      for (int w = 0; w < 2; w++) write(0, w, s, 1'b1);
    n_busy = 0; n_ack = 0; last_busy = -1; first_ack = -1;
    flash_req[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      flash_req[0] = 1'b0;
      if (busy[0] === 1'b1) begin n_busy++; last_busy = i; end
      if (ack[0] === 1'b1) begin n_ack++; if (first_ack < 0) first_ack = i; end
    end
    chk("flash_busy_cycles", n_busy, 4);
    chk("flash_ack_count", n_ack, 1);
    chk("flash_ack_after_busy", first_ack, last_busy + 1);
    for (int s = 0; s < 32; s++) begin
      rd_index[0] = 6'(s);
      tick();
      chk("flash_cleared", {30'd0, rd_vb0}, 32'd0);
    end

    // Flash and write together, plus a second flash mid-sweep.
    rd_index[0] = 6'd3;
    wr_en[0] = 1'b1; wr_way[0] = 2'd0; wr_index[0] = 6'd3; wr_bit[0] = 1'b1;
    flash_req[0] = 1'b1;
    #1 chk("flash_beats_write_rdy", {31'd0, wr_rdy[0]}, 32'd0);
    tick();
    wr_en[0] = 1'b0; flash_req[0] = 1'b0;
    n_ack = 0;
    tick();
    flash_req[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      flash_req[0] = 1'b0;
      if (ack[0] === 1'b1) n_ack++;
    end
    chk("single_ack", n_ack, 1);
    chk("write_lost", {30'd0, rd_vb0}, 32'd0);

    // Reset in the second sweep cycle aborts without ack.
    for (int i = 0; i < 12; i++)
      write(0, $urandom_range(0, 1), $urandom_range(0, 31), 1'b1);
    flash_req[0] = 1'b1;
    tick();
    flash_req[0] = 1'b0;
    tick();
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    n_ack = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ack[0] === 1'b1) n_ack++;
    end
    chk("abort_no_ack", n_ack, 0);
    chk("abort_wrrdy", {31'd0, wr_rdy[0]}, 32'd1);
    for (int s = 0; s < 32; s++) begin
      rd_index[0] = 6'(s);
      tick();
      chk("abort_cleared", {30'd0, rd_vb0}, 32'd0);
    end

    // Wide instance: single-cycle sweep.
    for (int i = 0; i < 24; i++)
      write(1, $urandom_range(0, 3), $urandom_range(0, 63), 1'b1);
    flash_req[1] = 1'b1;
    tick();
    flash_req[1] = 1'b0;
    chk("wide_busy", {31'd0, busy[1]}, 32'd1);
    tick();
    chk("wide_ack", {31'd0, ack[1]}, 32'd1);
    chk("wide_busy_off", {31'd0, busy[1]}, 32'd0);
    tick();
    chk("wide_ack_off", {31'd0, ack[1]}, 32'd0);
    for (int s = 0; s < 64; s++) begin
      rd_index[1] = 6'(s);
      tick();
      chk("wide_cleared", {28'd0, rd_vb1}, 32'd0);
    end

    // Random traffic on both instances.
    for (int i = 0; i < 400; i++) begin
      for (int d = 0; d < 2; d++) begin
        rst[d]       = ($urandom_range(0, 99) == 0);
        flash_req[d] = ($urandom_range(0, 24) == 0);
        wr_en[d]     = 1'($urandom_range(0, 1));
        wr_bit[d]    = ($urandom_range(0, 3) != 0);
        wr_way[d]    = 2'($urandom_range(0, nways[d] - 1));
        wr_index[d]  = 6'($urandom_range(0, nsets[d] - 1));
        rd_index[d]  = 6'($urandom_range(0, nsets[d] - 1));
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/p405s_icu_vb_array.md
P405S_ICU_VB_ARRAY -- requirements
Module: p405s_icu_vb_array

Interface
REQ-001 Parameter NUM_SETS, default 32: number of congruence classes; power of two, minimum 4.
REQ-002 Parameter NUM_WAYS, default 2: number of ways; range 1..8.
REQ-003 Parameter CLR_PER_CYC, default 8: sets cleared per sweep cycle; power of two, at most NUM_SETS.
REQ-004 Parameter IDX_W, default log2(NUM_SETS): set index width.
REQ-005 CB  input  1: sole clock; all state updates on rising edge.
REQ-006 reset  input  1: synchronous, active-high reset.
REQ-007 wrEn  input  1: request to write one valid bit.
REQ-008 wrWay  input  log2(NUM_WAYS), min 1: target way of write.
REQ-009 wrIndex  input  IDX_W: target set of write.
REQ-010 wrBit  input  1: value written (1 = validate, 0 = invalidate).
REQ-011 wrRdy  output  1: write accepted this cycle when wrEn & wrRdy.
REQ-012 rdIndex  input  IDX_W: set to read.
REQ-013 rdVb  output  NUM_WAYS: registered valid bits of set rdIndex, one bit per way.
REQ-014 flashReq  input  1: request to invalidate the whole array.
REQ-015 flashBusy  output  1: sweep in progress.
REQ-016 flashAck  output  1: one-cycle pulse on sweep completion.

Function
REQ-017 Storage SHALL be NUM_WAYS x NUM_SETS flops, vb[way][set].
REQ-018 Controller FSM SHALL have states IDLE, SWEEP, DONE.
- IDLE -> SWEEP on flashReq; sweep pointer loads 0.
- SWEEP: clear sets ptr..ptr+CLR_PER_CYC-1 in all ways; ptr += CLR_PER_CYC.
- SWEEP -> DONE in the cycle the last group (ptr = NUM_SETS-CLR_PER_CYC) is cleared.
- DONE -> IDLE unconditionally.
REQ-019 Sweep SHALL take exactly NUM_SETS/CLR_PER_CYC cycles in SWEEP; the sweep pointer is IDX_W bits and SHALL NOT be used past wrap.
REQ-020 flashBusy SHALL be 1 in SWEEP only; flashAck SHALL be 1 in DONE only.
REQ-021 flashReq in SWEEP or DONE SHALL be ignored: no restart, no queuing.
REQ-022 wrRdy SHALL equal (state==IDLE) & ~flashReq; flash wins over a same-cycle write, and that write is not accepted.
REQ-023 Accepted write SHALL update vb[wrWay][wrIndex] <= wrBit at the next edge; all other bits SHALL be unchanged.
REQ-024 rdVb SHALL have 1-cycle latency: at edge N+1 it holds the vb[*][rdIndex] values as updated at that same edge.
- Accepted write to the same index: rdVb SHALL show the new bit (write bypass).
- Sweep group containing rdIndex: rdVb SHALL show all zeros.
REQ-025 wrWay >= NUM_WAYS SHALL be dropped with no state change.

Reset
REQ-026 On reset, state SHALL be IDLE, all vb bits 0, ptr 0, rdVb 0, flashBusy 0, flashAck 0; wrRdy SHALL be 1 in the first cycle after reset with flashReq low.
REQ-027 Reset mid-sweep SHALL abort the sweep with no flashAck; the array still ends fully cleared.
REQ-028 Reset SHALL have priority over flashReq and wrEn in the same cycle.

Structure
REQ-029 The FSM state encoding (IDLE=2'b00, SWEEP=2'b01, DONE=2'b10) and the default parameter values SHALL live in the shared package p405s_icu_pkg.
REQ-030 One sub-module, p405s_icu_vb_sweep_ctl, SHALL contain the FSM and sweep pointer and output per-set clear enables; the storage and read path SHALL stay in the top module.

Verification
REQ-031 Reset, write way1 idx5 bit1, then read idx5 -> rdVb = 2'b10 one cycle later.
REQ-032 Write idx7 way0 bit1 with rdIndex=7 in the same cycle -> rdVb[0]=1 at the next edge (bypass).
REQ-033 Populate all bits, pulse flashReq (default params) -> flashBusy high exactly 4 cycles, then flashAck one cycle, then all reads return 0.
REQ-034 flashReq and wrEn together in IDLE -> wrRdy=0, write lost, sweep starts; a second flashReq mid-sweep -> still exactly one flashAck.
REQ-035 Reset asserted in the 2nd sweep cycle -> no flashAck, state IDLE, wrRdy=1, all rdVb 0.
REQ-036 Parameter sweep: NUM_SETS=64, NUM_WAYS=4, CLR_PER_CYC=64 -> a single-cycle sweep with correct flashAck timing.
